// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller for the tinyRISC ALU: accepts one instruction, reads
// operands, drives the ALU for one cycle and writes the result back or updates E/GT.
module alu_issue_ctrl #(
  parameter int DATA_W    = 32,
  parameter int RF_AW     = 4,
  parameter int RF_RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [31:0]       instr,
  output logic [RF_AW-1:0]  rf_raddr1,
  output logic [RF_AW-1:0]  rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic              rf_we,
  output logic [RF_AW-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [4:0]        alu_control,
  output logic [4:0]        alu_sel,
  input  logic [DATA_W-1:0] alu_result,
  output logic              flag_e,
  output logic              flag_gt,
  output logic              done,
  output logic              illegal
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_READ = 3'd1,
    S_EXEC = 3'd2,
    S_WB   = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  localparam logic [4:0] OP_CMP = 5'b00101;
  localparam logic [4:0] OP_NOT = 5'b01000;
  localparam logic [4:0] OP_MOV = 5'b01001;
  localparam logic [4:0] OP_LSL = 5'b01010;
  localparam logic [4:0] OP_LSR = 5'b01011;
  localparam logic [4:0] OP_ASR = 5'b01100;
  localparam logic [4:0] OP_NOP = 5'b01101;

  state_t             state;
  logic [4:0]         opc_q;
  logic               imm_en_q;
  logic [RF_AW-1:0]   rd_q;
  logic [17:0]        imm_q;
  logic [1:0]         rd_cnt;
  logic [DATA_W-1:0]  imm_ext;
  logic [DATA_W-1:0]  op2;
  logic               writes_rd;

  // Handshake: an instruction transfers on the rising edge where instr_valid and
  // instr_ready are both high; instr_ready is high exactly while the FSM is idle.
  assign instr_ready = (state == S_IDLE);
  assign alu_sel     = 5'd0;

  always_comb begin
    case (imm_q[17:16])
      2'b01:   imm_ext = {16'h0000, imm_q[15:0]};
      2'b10:   imm_ext = {imm_q[15:0], 16'h0000};
      default: imm_ext = {{16{imm_q[15]}}, imm_q[15:0]};
    endcase
  end

  assign op2       = imm_en_q ? imm_ext : rf_rdata2;
  assign writes_rd = (opc_q != OP_CMP) && (opc_q != OP_NOP);

  // ALU inputs are live only during EXEC so the ALU sees zeros whenever it is unused.
  always_comb begin
    alu_a       = '0;
    alu_b       = '0;
    alu_control = 5'd0;
    if (state == S_EXEC) begin
      case (opc_q)
        OP_NOT: begin
          alu_a       = op2;
          alu_b       = op2;
          alu_control = 5'b01000;
        end
        OP_MOV: begin
          alu_b       = op2;
          alu_control = 5'b00111;
        end
        OP_LSL: begin
          alu_a       = rf_rdata1;
          alu_b       = op2;
          alu_control = 5'b01001;
        end
        OP_LSR: begin
          alu_a       = rf_rdata1;
          alu_b       = op2;
          alu_control = 5'b01010;
        end
        OP_ASR: begin
          alu_a       = rf_rdata1;
          alu_b       = op2;
          alu_control = 5'b01011;
        end
        OP_NOP: begin
          alu_control = 5'd0;
        end
        default: begin
          alu_a       = rf_rdata1;
          alu_b       = op2;
          alu_control = opc_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      opc_q     <= 5'd0;
      imm_en_q  <= 1'b0;
      rd_q      <= '0;
      imm_q     <= 18'd0;
      rd_cnt    <= 2'd0;
      rf_raddr1 <= '0;
      rf_raddr2 <= '0;
      rf_we     <= 1'b0;
      rf_waddr  <= '0;
      rf_wdata  <= '0;
      flag_e    <= 1'b0;
      flag_gt   <= 1'b0;
      done      <= 1'b0;
      illegal   <= 1'b0;
    end else begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      done     <= 1'b0;
      illegal  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            opc_q     <= instr[31:27];
            imm_en_q  <= instr[26];
            rd_q      <= instr[25:22];
            imm_q     <= instr[17:0];
            rf_raddr1 <= instr[21:18];
            rf_raddr2 <= instr[17:14];
            rd_cnt    <= 2'd0;
            if (instr[31:27] <= OP_NOP) begin
              state <= S_READ;
            end else begin
              state   <= S_ERR;
              illegal <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (rd_cnt == 2'(RF_RD_LAT - 1)) begin
            state <= S_EXEC;
          end else begin
            rd_cnt <= rd_cnt + 2'd1;
          end
        end
        S_EXEC: begin
          state <= S_WB;
          done  <= 1'b1;
          if (writes_rd) begin
            rf_we    <= 1'b1;
            rf_waddr <= rd_q;
            rf_wdata <= alu_result;
          end
          if (opc_q == OP_CMP) begin
            flag_e  <= (alu_result == '0);
            flag_gt <= (alu_result == DATA_W'(1));
          end
        end
        S_WB:    state <= S_IDLE;
        S_ERR:   state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a register-file/ALU environment, a cycle-level reference
// model with a per-cycle compare, and directed vectors with literal expectations.
module tb_alu_issue_ctrl;
  localparam int LAT = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic        instr_valid, instr_ready;
  logic [31:0] instr;
  logic [3:0]  rf_raddr1, rf_raddr2, rf_waddr;
  logic [31:0] rf_rdata1, rf_rdata2, rf_wdata, alu_a, alu_b, alu_result;
  logic        rf_we, flag_e, flag_gt, done, illegal;
  logic [4:0]  alu_control, alu_sel;

  logic        b_instr_valid, b_instr_ready;
  logic [31:0] b_instr;
  logic [3:0]  b_rf_raddr1, b_rf_raddr2, b_rf_waddr;
  logic [31:0] b_rf_rdata1, b_rf_rdata2, b_rf_wdata, b_alu_a, b_alu_b, b_alu_result;
  logic        b_rf_we, b_flag_e, b_flag_gt, b_done, b_illegal;
  logic [4:0]  b_alu_control, b_alu_sel;

  alu_issue_ctrl #(.DATA_W(32), .RF_AW(4), .RF_RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_rdata1(rf_rdata1),
    .rf_rdata2(rf_rdata2), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control), .alu_sel(alu_sel),
    .alu_result(alu_result), .flag_e(flag_e), .flag_gt(flag_gt), .done(done),
    .illegal(illegal)
  );

  alu_issue_ctrl #(.DATA_W(32), .RF_AW(4), .RF_RD_LAT(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .instr_valid(b_instr_valid), .instr_ready(b_instr_ready),
    .instr(b_instr), .rf_raddr1(b_rf_raddr1), .rf_raddr2(b_rf_raddr2),
    .rf_rdata1(b_rf_rdata1), .rf_rdata2(b_rf_rdata2), .rf_we(b_rf_we),
    .rf_waddr(b_rf_waddr), .rf_wdata(b_rf_wdata), .alu_a(b_alu_a), .alu_b(b_alu_b),
    .alu_control(b_alu_control), .alu_sel(b_alu_sel), .alu_result(b_alu_result),
    .flag_e(b_flag_e), .flag_gt(b_flag_gt), .done(b_done), .illegal(b_illegal)
  );

  // ---------------- environment: register file and ALU ----------------
  logic [31:0] rf [16];
  logic [31:0] b_p1, b_p2;

  always @(posedge clk) begin
    rf_rdata1   <= rf[rf_raddr1];
    rf_rdata2   <= rf[rf_raddr2];
    b_p1        <= rf[b_rf_raddr1];
    b_p2        <= rf[b_rf_raddr2];
    b_rf_rdata1 <= b_p1;
    b_rf_rdata2 <= b_p2;
  end

  function automatic logic [31:0] alu_fn(input logic [4:0] c, input logic [31:0] a,
                                         input logic [31:0] b);
    case (c)
      5'd0:    return a + b;
      5'd1:    return a - b;
      5'd2:    return a * b;
      5'd3:    return (b == 0) ? 32'd0 : a / b;
      5'd4:    return (b == 0) ? 32'd0 : a % b;
      5'd5:    return (a == b) ? 32'd0 : ((a > b) ? 32'd1 : 32'd2);
      5'd6:    return a & b;
      5'd7:    return a | b;
      5'd8:    return ~a;
      5'd9:    return a << b[4:0];
      5'd10:   return a >> b[4:0];
      5'd11:   return $signed(a) >>> b[4:0];
      default: return 32'd0;
    endcase
  endfunction

  always_comb alu_result   = alu_fn(alu_control, alu_a, alu_b);
  always_comb b_alu_result = alu_fn(b_alu_control, b_alu_a, b_alu_b);

  // ---------------- scoring ----------------
  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- reference model (instruction-level timeline) ----------------
  int          m_cnt;
  logic        m_ill, m_wr, m_chk_alu, m_e, m_gt;
  logic [4:0]  m_opc, m_ec;
  logic [3:0]  m_rs1, m_rs2, m_rd;
  logic [31:0] m_v1, m_op2, m_ea, m_eb, m_res;

  function automatic logic [31:0] imm_val(input logic [17:0] imm);
    case (imm[17:16])
      2'b01:   return {16'h0, imm[15:0]};
      2'b10:   return {imm[15:0], 16'h0};
      default: return {{16{imm[15]}}, imm[15:0]};
    endcase
  endfunction

  function automatic logic [31:0] sem_res(input logic [4:0] opc, input logic [31:0] v1,
                                          input logic [31:0] v2);
    case (opc)
      5'd0:    return v1 + v2;
      5'd1:    return v1 - v2;
      5'd2:    return v1 * v2;
      5'd3:    return (v2 == 0) ? 32'd0 : v1 / v2;
      5'd4:    return (v2 == 0) ? 32'd0 : v1 % v2;
      5'd6:    return v1 & v2;
      5'd7:    return v1 | v2;
      5'd8:    return ~v2;
      5'd9:    return v2;
      5'd10:   return v1 << v2[4:0];
      5'd11:   return v1 >> v2[4:0];
      5'd12:   return $signed(v1) >>> v2[4:0];
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0;
      m_e   = 1'b0;
      m_gt  = 1'b0;
    end else if (m_cnt == 0) begin
      if (instr_valid) begin
        m_opc     = instr[31:27];
        m_ill     = (instr[31:27] > 5'd13);
        m_rd      = instr[25:22];
        m_rs1     = instr[21:18];
        m_rs2     = instr[17:14];
        m_v1      = rf[instr[21:18]];
        m_op2     = instr[26] ? imm_val(instr[17:0]) : rf[instr[17:14]];
        m_wr      = !(m_opc == 5'd5 || m_opc == 5'd13);
        m_res     = sem_res(m_opc, m_v1, m_op2);
        m_chk_alu = (m_opc != 5'd13);
        m_ea      = m_v1;
        m_eb      = m_op2;
        m_ec      = m_opc;
        case (m_opc)
          5'd8:  m_ea = m_op2;
          5'd9:  begin m_ea = 32'd0; m_ec = 5'd7; end
          5'd10: m_ec = 5'd9;
          5'd11: m_ec = 5'd10;
          5'd12: m_ec = 5'd11;
          default: ;
        endcase
        m_cnt = 1;
      end
    end else begin
      if (!m_ill && m_cnt == LAT + 1 && m_opc == 5'd5) begin
        m_e  = (m_v1 == m_op2);
        m_gt = (m_v1 > m_op2);
      end
      if (m_ill ? (m_cnt == 1) : (m_cnt == LAT + 2)) m_cnt = 0;
      else m_cnt++;
    end
  end

  logic c_exec, c_wb;
  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_ready", instr_ready, 1);
      check("rst_we", rf_we, 0);
      check("rst_waddr", rf_waddr, 0);
      check("rst_wdata", rf_wdata, 0);
      check("rst_raddr", {rf_raddr1, rf_raddr2}, 0);
      check("rst_alu", alu_a | alu_b | alu_control, 0);
      check("rst_pulses", {done, illegal}, 0);
      check("rst_flags", {flag_e, flag_gt}, 0);
    end else begin
      c_exec = !m_ill && (m_cnt == LAT + 1);
      c_wb   = !m_ill && (m_cnt == LAT + 2);
      check("cyc_ready", instr_ready, m_cnt == 0);
      check("cyc_alu_sel", alu_sel, 0);
      check("cyc_flags", {flag_e, flag_gt}, {m_e, m_gt});
      check("cyc_illegal", illegal, m_ill && m_cnt == 1);
      check("cyc_done", done, c_wb);
      check("cyc_we", rf_we, c_wb && m_wr);
      if (!m_ill && m_cnt >= 1 && m_cnt <= LAT + 1)
        check("cyc_raddr", {rf_raddr1, rf_raddr2}, {m_rs1, m_rs2});
      if (c_exec) begin
        if (m_chk_alu) begin
          check("cyc_alu_a", alu_a, m_ea);
          check("cyc_alu_b", alu_b, m_eb);
          check("cyc_alu_ctl", alu_control, m_ec);
        end
      end else begin
        check("cyc_alu_idle", alu_a | alu_b | alu_control, 0);
      end
      if (c_wb && m_wr) begin
        check("cyc_waddr", rf_waddr, m_rd);
        check("cyc_wdata", rf_wdata, m_res);
      end
    end
  end

  // ---------------- drivers ----------------
  typedef struct {
    logic [31:0] ea, eb;
    logic [4:0]  ec;
    int          wb_cyc, n_we, n_done, n_ill;
    logic [3:0]  waddr;
    logic [31:0] wdata;
    logic        rdy2;
  } obs_t;

  task automatic set_rf(input int idx, input logic [31:0] v);
    rf[idx] = v;
  endtask

  task automatic run1(input logic [31:0] ins, output obs_t o);
    int t;
    o = '{default: 0};
    o.wb_cyc = -1;
    t = 0;
    @(posedge clk); #2;
    instr_valid = 1'b1;
    instr = ins;
    while (!instr_ready && t < 20) begin
      @(posedge clk); #2;
      t++;
    end
    check("accept_ready", instr_ready, 1);
    @(posedge clk); #2;
    instr_valid = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == LAT + 1) begin
        o.ea = alu_a;
        o.eb = alu_b;
        o.ec = alu_control;
      end
      if (k == 2) o.rdy2 = instr_ready;
      if (rf_we) o.n_we++;
      if (illegal) o.n_ill++;
      if (done) begin
        o.n_done++;
        o.wb_cyc = k;
        o.waddr  = rf_waddr;
        o.wdata  = rf_wdata;
      end
    end
  endtask

  function automatic logic [31:0] enc_r(input logic [4:0] opc, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [3:0] rs2);
    return {opc, 1'b0, rd, rs1, rs2, 14'd0};
  endfunction

  function automatic logic [31:0] enc_i(input logic [4:0] opc, input logic [3:0] rd,
                                        input logic [3:0] rs1, input logic [17:0] imm);
    return {opc, 1'b1, rd, rs1, imm};
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  obs_t o;
  int   nwe;
  logic [31:0] ea6;

  initial begin
    instr_valid = 1'b0;
    instr = 32'd0;
    b_instr_valid = 1'b0;
    b_instr = 32'd0;
    for (int i = 0; i < 16; i++) rf[i] = 32'd0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("reset_ready", instr_ready, 1);
    check("reset_outs", {rf_we, done, illegal, flag_e, flag_gt}, 0);
    rst_n = 1'b1;

    // add r3,r1,r2
    set_rf(1, 32'd5); set_rf(2, 32'd7);
    run1(enc_r(5'd0, 4'd3, 4'd1, 4'd2), o);
    check("t1_ctl", o.ec, 5'b00000);
    check("t1_wb_cyc", o.wb_cyc, 3);
    check("t1_waddr", o.waddr, 3);
    check("t1_wdata", o.wdata, 32'd12);
    check("t1_pulses", {o.n_we, o.n_done}, {32'd1, 32'd1});

    // sub with sign-extended immediate
    set_rf(1, 32'd10);
    run1(enc_i(5'd1, 4'd2, 4'd1, 18'h0FFFF), o);
    check("t2_alu_b", o.eb, 32'hFFFFFFFF);
    check("t2_wdata", o.wdata, 32'd11);

    // cmp: less-than, equal, greater-than
    set_rf(1, 32'd3); set_rf(2, 32'd4);
    run1(enc_r(5'd5, 4'd0, 4'd1, 4'd2), o);
    check("t3_lt_flags", {flag_e, flag_gt}, 2'b00);
    set_rf(1, 32'd4);
    run1(enc_r(5'd5, 4'd0, 4'd1, 4'd2), o);
    check("t3_eq_flags", {flag_e, flag_gt}, 2'b10);
    check("t3_eq_nowe", o.n_we, 0);
    check("t3_eq_done", o.n_done, 1);
    set_rf(1, 32'd9);
    run1(enc_r(5'd5, 4'd0, 4'd1, 4'd2), o);
    check("t3_gt_flags", {flag_e, flag_gt}, 2'b01);

    // mov with shifted immediate
    run1(enc_i(5'd9, 4'd4, 4'd0, 18'h21234), o);
    check("t4_alu_a", o.ea, 32'd0);
    check("t4_ctl", o.ec, 5'b00111);
    check("t4_alu_b", o.eb, 32'h12340000);
    check("t4_wdata", o.wdata, 32'h12340000);
    check("t4_flags_hold", {flag_e, flag_gt}, 2'b01);

    // undefined opcode
    run1({5'b11111, 27'd0}, o);
    check("t5_illegal", o.n_ill, 1);
    check("t5_nowe", o.n_we, 0);
    check("t5_nodone", o.n_done, 0);
    check("t5_ready_next", o.rdy2, 1);

    // immediate modifiers 01 and 11, divide by zero, rd=r0, shifts, nop, misc ops
    set_rf(1, 32'd1);
    run1(enc_i(5'd0, 4'd5, 4'd1, 18'h1FFFF), o);
    check("imm01_b", o.eb, 32'h0000FFFF);
    check("imm01_wdata", o.wdata, 32'h00010000);
    set_rf(1, 32'd0);
    run1(enc_i(5'd0, 4'd5, 4'd1, 18'h38000), o);
    check("imm11_wdata", o.wdata, 32'hFFFF8000);
    set_rf(1, 32'd7); set_rf(2, 32'd0);
    run1(enc_r(5'd3, 4'd6, 4'd1, 4'd2), o);
    check("div0_wdata", o.wdata, 32'd0);
    check("div0_we", o.n_we, 1);
    set_rf(2, 32'd3);
    run1(enc_r(5'd4, 4'd0, 4'd1, 4'd2), o);
    check("mod_r0_waddr", o.waddr, 0);
    check("mod_r0_wdata", o.wdata, 32'd1);
    set_rf(1, 32'h80000000);
    run1(enc_i(5'd12, 4'd9, 4'd1, 18'h00004), o);
    check("asr_wdata", o.wdata, 32'hF8000000);
    run1(enc_i(5'd11, 4'd9, 4'd1, 18'h00004), o);
    check("lsr_wdata", o.wdata, 32'h08000000);
    set_rf(1, 32'd3);
    run1(enc_i(5'd10, 4'd8, 4'd1, 18'h00004), o);
    check("lsl_wdata", o.wdata, 32'd48);
    run1(enc_i(5'd8, 4'd10, 4'd0, 18'h10F0F), o);
    check("not_wdata", o.wdata, 32'hFFFFF0F0);
    set_rf(1, 32'h0000FF0F); set_rf(2, 32'h000000FF);
    run1(enc_r(5'd6, 4'd11, 4'd1, 4'd2), o);
    run1(enc_r(5'd7, 4'd12, 4'd1, 4'd2), o);
    run1(enc_r(5'd2, 4'd13, 4'd1, 4'd2), o);
    run1({5'd13, 27'd0}, o);
    check("nop_done", o.n_done, 1);
    check("nop_nowe", o.n_we, 0);

    // reset in EXEC with instr_valid held
    set_rf(1, 32'd5); set_rf(2, 32'd7);
    @(posedge clk); #2;
    instr_valid = 1'b1;
    instr = enc_r(5'd0, 4'd7, 4'd1, 4'd2);
    @(posedge clk);
    @(posedge clk); #2;
    ea6 = alu_a;
    check("t6_in_exec", ea6, 32'd5);
    rst_n = 1'b0;
    #1;
    check("t6_alu_zero", alu_a | alu_b | alu_control, 0);
    check("t6_flags_zero", {flag_e, flag_gt}, 0);
    check("t6_ready", instr_ready, 1);
    nwe = 0;
    repeat (2) begin
      @(negedge clk);
      if (rf_we || done) nwe++;
    end
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    if (rf_we || done) nwe++;
    check("t6_no_write", nwe, 0);
    @(posedge clk); #2;
    instr_valid = 1'b0;
    o = '{default: 0};
    o.wb_cyc = -1;
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (rf_we) o.n_we++;
      if (done) begin
        o.wb_cyc = k;
        o.waddr  = rf_waddr;
        o.wdata  = rf_wdata;
      end
    end
    check("t6_wb_cyc", o.wb_cyc, 3);
    check("t6_waddr", o.waddr, 7);
    check("t6_wdata", o.wdata, 32'd12);
    check("t6_we_once", o.n_we, 1);

    // RF_RD_LAT = 2 instance, add r3,r1,r2
    @(posedge clk); #2;
    b_instr_valid = 1'b1;
    b_instr = enc_r(5'd0, 4'd3, 4'd1, 4'd2);
    check("t7_ready", b_instr_ready, 1);
    @(posedge clk); #2;
    b_instr_valid = 1'b0;
    o = '{default: 0};
    o.wb_cyc = -1;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      if (k == 3) begin
        o.ea = b_alu_a;
        o.eb = b_alu_b;
        o.ec = b_alu_control;
      end
      if (b_rf_we) o.n_we++;
      if (b_done) begin
        o.wb_cyc = k;
        o.waddr  = b_rf_waddr;
        o.wdata  = b_rf_wdata;
      end
    end
    check("t7_exec_ab", {o.ea, o.eb}, {32'd5, 32'd7});
    check("t7_ctl", o.ec, 5'b00000);
    check("t7_wb_cyc", o.wb_cyc, 4);
    check("t7_waddr", o.waddr, 3);
    check("t7_wdata", o.wdata, 32'd12);
    check("t7_we_once", o.n_we, 1);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
